mult4x4_pp_accum: RTL and testbench

//  Sequencer/accumulator around the registered 2x2 multiplier stage; builds an N x N product.
//  - Splits captured operands into 2-bit digits and issues one digit pair per cycle to the 2x2 stage.
//  - Consumes each 4-bit partial product MUL_LAT cycles later and adds it, shifted, into a 2N-bit accumulator.
//  - Presents the result on a valid/ready output.
//  - Sits directly around the 2x2 stage: drives its operands and consumes its product.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult2x2_stage.sv | 27 ++
 rtl/pp_tag_pipe.sv | 35 +++
 rtl/mult4x4_pp_accum.sv | 121 ++++++++++++
 tb/tb_mult4x4_pp_accum.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types for the digit-serial multiplier slice: digit and partial-product
// widths, the sequencer state encoding and the shift tag that travels alongside
// each partial product through the 2x2 stage.
package mult_pkg;

  localparam int DIGIT_W = 2;  // operand digit fed to the 2x2 stage
  localparam int PP_W    = 4;  // 2x2 partial product width

  // Tag shift field is sized for the widest operand the sequencer supports
  // (N up to 128); narrower instances simply leave the top bits zero.
  localparam int SHIFT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [SHIFT_W-1:0] shift;
  } tag_t;

endpackage

// File: rtl/mult2x2_stage.sv
// Registered 2x2 unsigned multiplier, LAT register stages deep.
// Ports: Clk, rst_n (synchronous, active-low), a/b 2-bit digits, p 4-bit product
// valid LAT cycles after a/b are driven. No handshake; it accepts every cycle.
module mult2x2_stage #(
  parameter int LAT = 2
) (
  input  logic       Clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic [3:0] pipe [LAT];

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= {2'b00, a} * {2'b00, b};
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign p = pipe[LAT-1];

endmodule

// File: rtl/pp_tag_pipe.sv
// Shift register carrying partial-product tags in lockstep with the 2x2 stage.
// Ports: Clk, rst (synchronous, active-high), push tag in, pop tag out LAT cycles
// later, pending = a valid tag is still in flight behind the one now emerging.
module pp_tag_pipe
  import mult_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic Clk,
  input  logic rst,
  input  tag_t push,
  output tag_t pop,
  output logic pending
);

  tag_t stg [LAT];

  always_ff @(posedge Clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) stg[s] <= '0;
    end else begin
      stg[0] <= push;
      for (int s = 1; s < LAT; s++) stg[s] <= stg[s-1];
    end
  end

  assign pop = stg[LAT-1];

  // Every stage except the output one counts as "still coming".
  always_comb begin
    pending = 1'b0;
    for (int s = 0; s < LAT - 1; s++) pending = pending | stg[s].valid;
  end

endmodule

// File: rtl/mult4x4_pp_accum.sv
// N x N unsigned multiplier built by sequencing digit pairs through an external
// registered 2x2 stage and accumulating the shifted partial products.
// Ports: Clk, rst (sync, active-high); in_valid/in_ready + a/b operand input;
// mul_a/mul_b out to the 2x2 stage, mul_p back from it; out_valid/out_ready +
// product result. Accepts one operand pair only in IDLE; holds the result until
// out_ready.
module mult4x4_pp_accum
  import mult_pkg::*;
#(
  parameter int N       = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                Clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  output logic [DIGIT_W-1:0]  mul_a,
  output logic [DIGIT_W-1:0]  mul_b,
  input  logic [PP_W-1:0]     mul_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*N-1:0]      product
);

  localparam int D     = N / DIGIT_W;
  localparam int NPP   = D * D;
  localparam int K_W   = $clog2(NPP + 1);
  localparam int ACC_W = 2 * N;

  state_t           state;
  logic [K_W-1:0]   k;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  tag_t             push;
  tag_t             pop;
  logic             pending;
  logic             last_issue;
  logic             drain_done;
  int               di;
  int               dj;

  // Issue side: digit i of a walks fastest, digit j of b steps every D cycles.
  always_comb begin
    di    = int'(k) % D;
    dj    = int'(k) / D;
    mul_a = '0;
    mul_b = '0;
    push  = '0;
    if (state == ISSUE) begin
      mul_a      = DIGIT_W'(a_r >> (DIGIT_W * di));
      mul_b      = DIGIT_W'(b_r >> (DIGIT_W * dj));
      push.valid = 1'b1;
      push.shift = SHIFT_W'(DIGIT_W * (di + dj));
    end
  end

  pp_tag_pipe #(.LAT(MUL_LAT)) u_tag_pipe (
    .Clk     (Clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .pending (pending)
  );

  // mul_p only means something when a valid tag emerges with it.
  always_comb begin
    acc_nxt = acc;
    if (pop.valid) acc_nxt = acc + (ACC_W'(mul_p) << pop.shift);
  end

  assign last_issue = (k == K_W'(NPP - 1));
  assign drain_done = pop.valid && !pending;

  always_ff @(posedge Clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            k     <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // With a short stage latency, early products land while still issuing.
          acc <= acc_nxt;
          k   <= k + 1'b1;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          acc <= acc_nxt;
          if (drain_done) begin
            product <= acc_nxt;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mult4x4_pp_accum.sv
// Self-checking bench for mult4x4_pp_accum with the registered 2x2 stage attached.
// Ports: none; drives a 4-bit instance (MUL_LAT=2) and a 6-bit instance (MUL_LAT=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult4x4_pp_accum;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b;
  logic [1:0] mul_a, mul_b;
  logic [3:0] mul_p;
  logic [7:0] product;

  logic        in6_valid, in6_ready, out6_valid, out6_ready;
  logic [5:0]  a6, b6;
  logic [1:0]  mul6_a, mul6_b;
  logic [3:0]  mul6_p;
  logic [11:0] product6;

  mult4x4_pp_accum #(.N(4), .MUL_LAT(2)) u_dut (
    .Clk(Clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  mult2x2_stage #(.LAT(2)) u_mul (
    .Clk(Clk), .rst_n(~rst), .a(mul_a), .b(mul_b), .p(mul_p)
  );

  mult4x4_pp_accum #(.N(6), .MUL_LAT(3)) u_dut6 (
    .Clk(Clk), .rst(rst), .in_valid(in6_valid), .in_ready(in6_ready), .a(a6), .b(b6),
    .mul_a(mul6_a), .mul_b(mul6_b), .mul_p(mul6_p),
    .out_valid(out6_valid), .out_ready(out6_ready), .product(product6)
  );

  mult2x2_stage #(.LAT(3)) u_mul6 (
    .Clk(Clk), .rst_n(~rst), .a(mul6_a), .b(mul6_b), .p(mul6_p)
  );

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] vp;
    int         vlat;
  } vec_t;

  vec_t vt [8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation on the 4-bit instance; called at a falling edge.
  // stall_pct: chance per cycle of withholding out_ready.
  // hold: keep in_valid high with junk operands while busy.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input int stall_pct,
                        input bit hold, output logic [7:0] got, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge Clk);
      guard++;
    end
    check("idle_wait", longint'(in_ready), 1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tbv;
    out_ready = 1'b0;
    @(negedge Clk);
    lat = 1;
    if (!hold) in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    while (!out_valid && lat < 40) begin
      if (hold) check("busy_in_ready", longint'(in_ready), 0);
      @(negedge Clk);
      lat++;
      a = 4'($urandom);
      b = 4'($urandom);
    end
    check("out_valid_seen", longint'(out_valid), 1);
    got       = product;
    out_ready = ($urandom_range(0, 99) >= stall_pct);
    guard     = 0;
    while (!out_ready) begin
      @(negedge Clk);
      guard++;
      check("stall_valid", longint'(out_valid), 1);
      check("stall_product", longint'(product), longint'(got));
      if (hold) check("done_in_ready", longint'(in_ready), 0);
      a = 4'($urandom);
      b = 4'($urandom);
      out_ready = (guard >= 6) || ($urandom_range(0, 99) >= stall_pct);
    end
    @(negedge Clk);
    out_ready = 1'b0;
    check("out_valid_drop", longint'(out_valid), 0);
  endtask

  // One operation on the 6-bit instance with out_ready held high.
  task automatic run_op6(input logic [5:0] ta, input logic [5:0] tbv,
                         output logic [11:0] got, output int lat);
    in6_valid = 1'b1;
    a6        = ta;
    b6        = tbv;
    @(negedge Clk);
    in6_valid = 1'b0;
    lat       = 1;
    while (!out6_valid && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    check("op6_valid_seen", longint'(out6_valid), 1);
    got = product6;
    @(negedge Clk);
    check("op6_valid_drop", longint'(out6_valid), 0);
  endtask

  initial begin
    logic [7:0]  got;
    logic [11:0] got6;
    logic [5:0]  ra, rb;
    int          lat;

    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = 4'h0;
    b          = 4'h0;
    out_ready  = 1'b0;
    in6_valid  = 1'b0;
    a6         = '0;
    b6         = '0;
    out6_ready = 1'b1;

    vt[0] = '{4'hF, 4'hF, 8'hE1, 7};
    vt[1] = '{4'h0, 4'h9, 8'h00, 7};
    vt[2] = '{4'h7, 4'h6, 8'h2A, 7};
    vt[3] = '{4'h1, 4'h1, 8'h01, 7};
    vt[4] = '{4'hF, 4'h1, 8'h0F, 7};
    vt[5] = '{4'hA, 4'h5, 8'h32, 7};
    vt[6] = '{4'h8, 4'h8, 8'h40, 7};
    vt[7] = '{4'hC, 4'hD, 8'h9C, 7};

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_product", longint'(product), 0);
    check("rst_mul_a", longint'(mul_a), 0);
    check("rst_mul_b", longint'(mul_b), 0);
    check("rst6_in_ready", longint'(in6_ready), 1);
    check("rst6_out_valid", longint'(out6_valid), 0);
    check("rst6_product", longint'(product6), 0);
    rst = 1'b0;
    @(negedge Clk);

    // Directed vectors, out_ready always high
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].va, vt[i].vb, 0, 1'b0, got, lat);
      check($sformatf("vec%0d_product", i), longint'(got), longint'(vt[i].vp));
      check($sformatf("vec%0d_latency", i), lat, vt[i].vlat);
    end

    // in_valid held high with junk operands across back-to-back ops
    run_op(4'h5, 4'h3, 0, 1'b1, got, lat);
    check("hold0_product", longint'(got), 15);
    check("hold0_latency", lat, 7);
    run_op(4'h9, 4'hE, 40, 1'b1, got, lat);
    check("hold1_product", longint'(got), 126);
    check("hold1_latency", lat, 7);
    run_op(4'hF, 4'h2, 0, 1'b1, got, lat);
    check("hold2_product", longint'(got), 30);
    check("hold2_latency", lat, 7);
    in_valid = 1'b0;
    @(negedge Clk);

    // Reset during the second issue cycle aborts the operation
    in_valid = 1'b1;
    a        = 4'hB;
    b        = 4'h6;
    @(negedge Clk);
    in_valid = 1'b0;
    check("iss0_mul_a", longint'(mul_a), 3);
    check("iss0_mul_b", longint'(mul_b), 2);
    @(negedge Clk);
    check("iss1_mul_a", longint'(mul_a), 2);
    check("iss1_mul_b", longint'(mul_b), 2);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0;
    check("abort_in_ready", longint'(in_ready), 1);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_mul_a", longint'(mul_a), 0);
    check("abort_mul_b", longint'(mul_b), 0);
    run_op(4'h7, 4'h6, 0, 1'b0, got, lat);
    check("post_abort_product", longint'(got), 42);
    check("post_abort_latency", lat, 7);

    // Every operand pair under random backpressure
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 30, 1'b0, got, lat);
        check($sformatf("all_%0d_%0d", x, y), longint'(got), x * y);
        if (lat != 7) check($sformatf("all_lat_%0d_%0d", x, y), lat, 7);
      end
    end

    // Wider instance: corner value then random operands
    run_op6(6'd63, 6'd63, got6, lat);
    check("op6_max_product", longint'(got6), 3969);
    check("op6_max_latency", lat, 13);
    for (int r = 0; r < 6; r++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      run_op6(ra, rb, got6, lat);
      check($sformatf("op6_rand_%0d_%0d", ra, rb), longint'(got6), int'(ra) * int'(rb));
      check("op6_rand_latency", lat, 13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
